// File: rtl/wb_write_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_port_scheduler
// Brief    : Serialises dual WB writes onto a single register-file write port.
// Revision : 1.0
// ============================================================================
module wb_write_port_scheduler #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int LOW_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reglow_write_in,
    input  logic [ADDR_W-1:0] Rdst1_in,
    input  logic [DATA_W-1:0] Rdst1_val_in,
    input  logic              reghigh_write_in,
    input  logic [ADDR_W-1:0] Rdst2_in,
    input  logic [DATA_W-1:0] Rdst2_val_in,
    output logic              rf_we_out,
    output logic [ADDR_W-1:0] rf_addr_out,
    output logic [DATA_W-1:0] rf_data_out,
    output logic              stall_out,
    output logic              busy_out,
    output logic [CNT_W-1:0]  dual_cnt_out
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic [ADDR_W-1:0] w_hold_addr_nxt;
    logic [DATA_W-1:0] w_hold_data_nxt;
    logic [CNT_W-1:0]  r_dual_cnt;
    logic              w_capture;
    logic              w_both;
    logic              w_same_idx;

    assign w_both     = reglow_write_in & reghigh_write_in;
    assign w_same_idx = (Rdst1_in == Rdst2_in);

    always_comb begin
        w_next_state    = r_state;
        w_capture       = 1'b0;
        w_hold_addr_nxt = Rdst2_in;
        w_hold_data_nxt = Rdst2_val_in;
        rf_we_out       = 1'b0;
        rf_addr_out     = '0;
        rf_data_out     = '0;
        stall_out       = 1'b0;
        busy_out        = 1'b0;
        // Reset forces every write-side output low, including mid-drain.
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (w_both && w_same_idx) begin
                        rf_we_out   = 1'b1;
                        rf_addr_out = Rdst1_in;
                        rf_data_out = Rdst1_val_in;
                    end else if (w_both) begin
                        rf_we_out    = 1'b1;
                        stall_out    = 1'b1;
                        w_capture    = 1'b1;
                        w_next_state = DRAIN;
                        if (LOW_FIRST != 0) begin
                            rf_addr_out     = Rdst1_in;
                            rf_data_out     = Rdst1_val_in;
                            w_hold_addr_nxt = Rdst2_in;
                            w_hold_data_nxt = Rdst2_val_in;
                        end else begin
                            rf_addr_out     = Rdst2_in;
                            rf_data_out     = Rdst2_val_in;
                            w_hold_addr_nxt = Rdst1_in;
                            w_hold_data_nxt = Rdst1_val_in;
                        end
                    end else if (reglow_write_in) begin
                        rf_we_out   = 1'b1;
                        rf_addr_out = Rdst1_in;
                        rf_data_out = Rdst1_val_in;
                    end else if (reghigh_write_in) begin
                        rf_we_out   = 1'b1;
                        rf_addr_out = Rdst2_in;
                        rf_data_out = Rdst2_val_in;
                    end
                end
                DRAIN: begin
                    // WB inputs repeat the frozen instruction here and are ignored.
                    rf_we_out    = 1'b1;
                    rf_addr_out  = r_hold_addr;
                    rf_data_out  = r_hold_data;
                    busy_out     = 1'b1;
                    w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_dual_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_hold_addr <= w_hold_addr_nxt;
                r_hold_data <= w_hold_data_nxt;
                if (r_dual_cnt != {CNT_W{1'b1}}) begin
                    r_dual_cnt <= r_dual_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign dual_cnt_out = r_dual_cnt;

endmodule
`default_nettype wire
